// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the multi-channel timer.
package timer_pkg;

   localparam logic [2:0] REG_CTRL = 3'd0;
   localparam logic [2:0] REG_PSCR = 3'd1;
   localparam logic [2:0] REG_AR   = 3'd2;
   localparam logic [2:0] REG_CNTR = 3'd3;
   localparam logic [2:0] REG_STAT = 3'd4;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_IE      = 1;
   localparam int unsigned CTRL_ONESHOT = 2;
   localparam int unsigned CTRL_DOWN    = 3;
   localparam int unsigned CTRL_TSEL    = 4;
   localparam int unsigned CTRL_W       = 5;

   localparam int unsigned STAT_EN  = 0;
   localparam int unsigned STAT_OVF = 1;

endpackage

// File: rtl/timer_ch.sv
// One timer channel: control registers, external-tick synchroniser, prescaler,
// up/down counter with auto-reload and sticky overflow flag.
module timer_ch
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned PSCR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  i_din,
   input  logic              i_wr_ctrl,
   input  logic              i_wr_pscr,
   input  logic              i_wr_ar,
   input  logic              i_wr_cntr,
   input  logic              i_wr_stat,
   input  logic              i_ext_tick,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [PSCR_W-1:0] o_pscr,
   output logic [WIDTH-1:0]  o_ar,
   output logic [WIDTH-1:0]  o_cntr,
   output logic              o_ovf
);

   logic [CTRL_W-1:0] r_ctrl;
   logic [PSCR_W-1:0] r_pscr;
   logic [PSCR_W-1:0] r_pre;
   logic [WIDTH-1:0]  r_ar;
   logic [WIDTH-1:0]  r_cntr;
   logic              r_ovf;
   logic [1:0]        r_sync;
   logic              r_ext_q;

   logic w_en, w_oneshot, w_down, w_tsel;
   logic w_event, w_tick, w_wrap, w_match;

   assign w_en      = r_ctrl[CTRL_EN];
   assign w_oneshot = r_ctrl[CTRL_ONESHOT];
   assign w_down    = r_ctrl[CTRL_DOWN];
   assign w_tsel    = r_ctrl[CTRL_TSEL];

   assign w_event = w_tsel ? (r_sync[1] & ~r_ext_q) : 1'b1;
   assign w_tick  = w_en & w_event & (r_pre == r_pscr);
   assign w_wrap  = w_down ? (r_cntr == '0) : (r_cntr == r_ar);
   // A CNTR write on the tick cycle swallows the tick, including its match.
   assign w_match = w_tick & ~i_wr_cntr & w_wrap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync  <= '0;
         r_ext_q <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_ext_tick};
         r_ext_q <= r_sync[1];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pre <= '0;
      end else if (i_wr_pscr || !w_en) begin
         r_pre <= '0;
      end else if (w_event) begin
         r_pre <= w_tick ? '0 : r_pre + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ctrl <= '0;
         r_pscr <= '0;
         r_ar   <= '0;
      end else begin
         if (i_wr_ctrl) begin
            r_ctrl <= i_din[CTRL_W-1:0];
         end else if (w_match && w_oneshot) begin
            r_ctrl[CTRL_EN] <= 1'b0;
         end
         if (i_wr_pscr) r_pscr <= i_din[PSCR_W-1:0];
         if (i_wr_ar)   r_ar   <= i_din;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cntr <= '0;
      end else if (i_wr_cntr) begin
         r_cntr <= i_din;
      end else if (w_tick) begin
         if (w_wrap) r_cntr <= w_down ? r_ar : '0;
         else        r_cntr <= w_down ? r_cntr - 1'b1 : r_cntr + 1'b1;
      end
   end

   // Set beats W1C clear when both land on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ovf <= 1'b0;
      end else if (w_match) begin
         r_ovf <= 1'b1;
      end else if (i_wr_stat && i_din[STAT_OVF]) begin
         r_ovf <= 1'b0;
      end
   end

   assign o_ctrl = r_ctrl;
   assign o_pscr = r_pscr;
   assign o_ar   = r_ar;
   assign o_cntr = r_cntr;
   assign o_ovf  = r_ovf;

endmodule

// File: rtl/timer_mc.sv
// Multi-channel timer top: address decode, per-channel write strobes,
// registered read mux and interrupt OR.
module timer_mc
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NCH    = 2,
   parameter int unsigned PSCR_W = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [WIDTH-1:0]         din,
   input  logic                     cs,
   input  logic [3+$clog2(NCH)-1:0] addr,
   input  logic                     wen,
   input  logic [NCH-1:0]           ext_tick,
   output logic [WIDTH-1:0]         dout,
   output logic                     irq
);

   localparam int unsigned AW = 3 + $clog2(NCH);

   logic [AW:0]       w_ch_idx;
   logic              w_ch_ok;
   logic [2:0]        w_reg;
   logic              w_wr;
   logic [CTRL_W-1:0] w_ctrl [NCH];
   logic [PSCR_W-1:0] w_pscr [NCH];
   logic [WIDTH-1:0]  w_ar   [NCH];
   logic [WIDTH-1:0]  w_cntr [NCH];
   logic [NCH-1:0]    w_ovf;
   logic [NCH-1:0]    w_irq_vec;
   logic [WIDTH-1:0]  w_rdata;
   logic [WIDTH-1:0]  r_dout;

   // Shift rather than slice so NCH=1 (no channel bits) still elaborates.
   assign w_ch_idx = {1'b0, addr} >> 3;
   assign w_ch_ok  = w_ch_idx < (AW+1)'(NCH);
   assign w_reg    = addr[2:0];
   assign w_wr     = cs & wen & w_ch_ok;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic w_sel;
      assign w_sel = w_wr & (w_ch_idx == (AW+1)'(g));

      timer_ch #(
         .WIDTH  (WIDTH),
         .PSCR_W (PSCR_W)
      ) u_ch (
         .clk        (clk),
         .reset_n    (reset_n),
         .i_din      (din),
         .i_wr_ctrl  (w_sel && (w_reg == REG_CTRL)),
         .i_wr_pscr  (w_sel && (w_reg == REG_PSCR)),
         .i_wr_ar    (w_sel && (w_reg == REG_AR)),
         .i_wr_cntr  (w_sel && (w_reg == REG_CNTR)),
         .i_wr_stat  (w_sel && (w_reg == REG_STAT)),
         .i_ext_tick (ext_tick[g]),
         .o_ctrl     (w_ctrl[g]),
         .o_pscr     (w_pscr[g]),
         .o_ar       (w_ar[g]),
         .o_cntr     (w_cntr[g]),
         .o_ovf      (w_ovf[g])
      );

      assign w_irq_vec[g] = w_ovf[g] & w_ctrl[g][CTRL_IE];
   end

   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_ch_idx == (AW+1)'(i)) begin
            case (w_reg)
               REG_CTRL: w_rdata = WIDTH'(w_ctrl[i]);
               REG_PSCR: w_rdata = WIDTH'(w_pscr[i]);
               REG_AR:   w_rdata = w_ar[i];
               REG_CNTR: w_rdata = w_cntr[i];
               REG_STAT: w_rdata = WIDTH'({w_ovf[i], w_ctrl[i][STAT_EN]});
               default:  w_rdata = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dout <= '0;
      end else if (cs && !wen) begin
         r_dout <= w_rdata;
      end
   end

   assign dout = r_dout;
   assign irq  = |w_irq_vec;

endmodule

// File: tb/tb_timer_mc.sv
// Directed self-checking bench for timer_mc (three channels, so index 3 is out of range).
module tb_timer_mc;
   import timer_pkg::*;

   localparam int unsigned NCH = 3;
   localparam int unsigned AW  = 5;

   logic            clk      = 1'b0;
   logic            reset_n  = 1'b0;
   logic [31:0]     din      = '0;
   logic            cs       = 1'b0;
   logic            wen      = 1'b0;
   logic [AW-1:0]   addr     = '0;
   logic [NCH-1:0]  ext_tick = '0;
   logic [31:0]     dout;
   logic            irq;

   int n_chk  = 0;
   int n_pass = 0;

   timer_mc #(
      .WIDTH  (32),
      .NCH    (NCH),
      .PSCR_W (8)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .din      (din),
      .cs       (cs),
      .addr     (addr),
      .wen      (wen),
      .ext_tick (ext_tick),
      .dout     (dout),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Tasks are entered on a negedge and return on the next one, so calls run back to back.
   task automatic wr(input logic [1:0] ch, input logic [2:0] r, input logic [31:0] d);
      cs = 1'b1; wen = 1'b1; addr = {ch, r}; din = d;
      @(negedge clk);
      cs = 1'b0; wen = 1'b0;
   endtask

   task automatic rd_chk(input logic [1:0] ch, input logic [2:0] r, input string tag,
                         input logic [31:0] exp);
      cs = 1'b1; wen = 1'b0; addr = {ch, r};
      @(negedge clk);
      cs = 1'b0;
      check(tag, dout, exp);
   endtask

   task automatic pulse_ext0();
      ext_tick[0] = 1'b1;
      repeat (3) @(negedge clk);
      ext_tick[0] = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   logic [31:0] down_seq [8];
   logic [31:0] ext_seq  [4];

   initial begin
      down_seq = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd5, 32'd5};
      ext_seq  = '{32'd0, 32'd1, 32'd1, 32'd0};

      #1;
      check("rst_dout", dout, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd_chk(0, REG_CTRL, "rst_ctrl", 32'h0);
      rd_chk(0, REG_CNTR, "rst_cntr", 32'h0);
      rd_chk(1, REG_STAT, "rst_stat", 32'h0);

      // Ch0 up count: PSCR=3, AR=4, EN|IE; stream CNTR reads every cycle.
      wr(0, REG_PSCR, 32'd3);
      wr(0, REG_AR, 32'd4);
      rd_chk(0, REG_PSCR, "pscr_rb", 32'd3);
      wr(0, REG_CTRL, 32'h3);
      cs = 1'b1; wen = 1'b0; addr = {2'd0, REG_CNTR};
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         check($sformatf("up_cntr_%0d", j), dout, 32'((j - 1) / 4 % 5));
         if (j == 19) check("irq_pre", {31'b0, irq}, 32'h0);
         if (j == 20) check("irq_rise", {31'b0, irq}, 32'h1);
      end
      cs = 1'b0;
      wr(0, REG_CTRL, 32'h0);
      wr(0, REG_STAT, 32'h2);
      check("irq_clr", {31'b0, irq}, 32'h0);
      rd_chk(0, REG_STAT, "stat_clr", 32'h0);

      // Ch1 one-shot down count from 5.
      wr(1, REG_AR, 32'd5);
      wr(1, REG_CNTR, 32'd5);
      wr(1, REG_PSCR, 32'd0);
      wr(1, REG_CTRL, 32'hD);
      cs = 1'b1; wen = 1'b0; addr = {2'd1, REG_CNTR};
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         check($sformatf("dn_cntr_%0d", j), dout, down_seq[j-1]);
      end
      cs = 1'b0;
      rd_chk(1, REG_CTRL, "os_ctrl", 32'hC);
      rd_chk(1, REG_STAT, "os_stat", 32'h2);
      rd_chk(1, REG_CNTR, "os_hold", 32'd5);
      check("os_irq", {31'b0, irq}, 32'h0);

      // Ch0 external ticks: PSCR=1, AR=1.
      wr(0, REG_CNTR, 32'd0);
      wr(0, REG_PSCR, 32'd1);
      wr(0, REG_AR, 32'd1);
      wr(0, REG_CTRL, 32'h11);
      for (int p = 0; p < 4; p++) begin
         pulse_ext0();
         rd_chk(0, REG_CNTR, $sformatf("ext_cntr_%0d", p + 1), ext_seq[p]);
         if (p == 2) rd_chk(0, REG_STAT, "ext_stat3", 32'h1);
         if (p == 3) rd_chk(0, REG_STAT, "ext_stat4", 32'h3);
      end

      // CTRL write on the one-shot match cycle keeps EN.
      wr(0, REG_CTRL, 32'h0);
      wr(0, REG_CNTR, 32'd0);
      wr(0, REG_AR, 32'd0);
      wr(0, REG_PSCR, 32'd0);
      wr(0, REG_STAT, 32'h2);
      wr(0, REG_CTRL, 32'h5);
      wr(0, REG_CTRL, 32'h5);
      rd_chk(0, REG_CTRL, "ctrl_wins", 32'h5);
      rd_chk(0, REG_STAT, "os_ar0", 32'h2);

      // CNTR write on a would-be match tick: write wins, no match.
      wr(0, REG_CTRL, 32'h0);
      wr(0, REG_STAT, 32'h2);
      wr(0, REG_AR, 32'h30);
      wr(0, REG_CNTR, 32'd0);
      wr(0, REG_CTRL, 32'h9);
      wr(0, REG_CNTR, 32'h10);
      rd_chk(0, REG_CNTR, "cntr_wins", 32'h10);
      rd_chk(0, REG_STAT, "no_match", 32'h1);

      // W1C alone clears; W1C on a match cycle loses.
      wr(0, REG_CTRL, 32'h0);
      wr(0, REG_AR, 32'd0);
      wr(0, REG_CNTR, 32'd0);
      wr(0, REG_STAT, 32'h2);
      rd_chk(0, REG_STAT, "w1c_alone", 32'h0);
      wr(0, REG_CTRL, 32'h1);
      wr(0, REG_STAT, 32'h2);
      rd_chk(0, REG_STAT, "set_wins", 32'h3);
      wr(0, REG_CTRL, 32'h0);
      wr(0, REG_STAT, 32'h2);

      // Unmapped register and out-of-range channel.
      rd_chk(1, REG_CNTR, "pre_bad", 32'd5);
      rd_chk(0, 3'd5, "addr5", 32'h0);
      wr(0, 3'd5, 32'hFFFF);
      wr(3, REG_CNTR, 32'h77);
      rd_chk(1, REG_CNTR, "pre_bad2", 32'd5);
      rd_chk(3, REG_CNTR, "ch_oob", 32'h0);
      rd_chk(2, REG_CNTR, "ch2_cntr", 32'h0);

      // Reset mid-count.
      wr(1, REG_AR, 32'd0);
      wr(1, REG_CTRL, 32'h3);
      @(negedge clk);
      check("irq_ch1", {31'b0, irq}, 32'h1);
      rd_chk(1, REG_CTRL, "pre_rst", 32'h3);
      reset_n = 1'b0;
      #1;
      check("mid_rst_dout", dout, 32'h0);
      check("mid_rst_irq", {31'b0, irq}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      rd_chk(1, REG_CTRL, "post_ctrl", 32'h0);
      rd_chk(1, REG_AR, "post_ar", 32'h0);
      rd_chk(1, REG_STAT, "post_stat", 32'h0);
      rd_chk(0, REG_PSCR, "post_pscr", 32'h0);
      repeat (5) @(negedge clk);
      rd_chk(1, REG_CNTR, "post_idle", 32'h0);
      check("post_irq", {31'b0, irq}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
